// File: rtl/tick_rate_detect_pkg.sv
// Shared types and helpers for the game-tick rate detector.
// Holds rate code constants, FSM state enum, classifier result and interval math.
`timescale 1ns/1ps
package tick_rate_detect_pkg;

    localparam logic [1:0] RATE_X1 = 2'd0;
    localparam logic [1:0] RATE_X2 = 2'd1;
    localparam logic [1:0] RATE_X4 = 2'd2;
    localparam logic [1:0] RATE_X8 = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIMED = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] code;
    } class_t;

    // Toggle interval produced by the divider for a given rate code.
    function automatic logic [63:0] expected_interval(
        input logic [31:0] base,
        input logic [1:0]  code
    );
        return ({32'd0, base} << code) + 64'd1;
    endfunction

endpackage

// File: rtl/tick_rate_detect_sync_edge_det.sv
// Two-flop synchronizer plus history flop; flags any toggle of din.
// Ports: clk, rst (sync, active high), din (async level), edge_stb (toggle seen).
`timescale 1ns/1ps
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic edge_stb
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_stb = s2 ^ s3;

endmodule

// File: rtl/tick_rate_detect.sv
// Measures the toggle interval of clk_game and decodes its divider rate code.
// Ports: clk, rst, clk_game in; rate, rate_valid, meas, meas_stb, err, timeout out.
`timescale 1ns/1ps
module tick_rate_detect
    import tick_rate_detect_pkg::*;
#(
    parameter int unsigned BASE_CNT = 12500,
    parameter int unsigned TOL      = 64,
    parameter int unsigned LOCK_N   = 2,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_game,
    output logic [1:0]       rate,
    output logic             rate_valid,
    output logic [CNT_W-1:0] meas,
    output logic             meas_stb,
    output logic             err,
    output logic             timeout
);

    localparam int MC_W = $clog2(LOCK_N + 1);
    localparam logic [MC_W-1:0] LOCK_LIM = MC_W'(LOCK_N);
    localparam logic [MC_W-1:0] MC_ONE   = MC_W'(1);
    localparam logic [CNT_W:0]  ONE_W    = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]  TOL_W    = (CNT_W+1)'(TOL);
    localparam logic [CNT_W:0]  E3_W     =
        (CNT_W+1)'(expected_interval(BASE_CNT, RATE_X8));
    // Timeout fires when the running interval would exceed the widest
    // accepted interval for the slowest code.
    localparam logic [CNT_W:0]  TO_LIM   = E3_W + TOL_W + ONE_W;

    logic             edge_stb;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W:0]   cnt_p1;
    logic [CNT_W-1:0] meas_sat;
    logic [MC_W-1:0]  mcnt;
    logic [MC_W-1:0]  mcnt_n;
    logic [MC_W-1:0]  mcnt_nxt;
    logic [1:0]       cand;
    logic [1:0]       cand_n;
    logic [1:0]       rate_n;
    logic             rv_n;
    logic [CNT_W-1:0] meas_n;
    logic             stb_n;
    logic             err_n;
    logic             to_n;
    logic             to_hit;
    logic [CNT_W:0]   e_k;
    logic [CNT_W:0]   dist_k;
    class_t           cls;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst      (rst),
        .din      (clk_game),
        .edge_stb (edge_stb)
    );

    assign cnt_p1   = {1'b0, cnt} + ONE_W;
    assign meas_sat = cnt_p1[CNT_W] ? '1 : cnt_p1[CNT_W-1:0];
    assign to_hit   = !edge_stb && (cnt_p1 == TO_LIM);

    // Scan from the slowest code down so the lowest matching code wins.
    always_comb begin
        cls    = '0;
        e_k    = '0;
        dist_k = '0;
        for (int k = 3; k >= 0; k--) begin
            e_k = (CNT_W+1)'(expected_interval(BASE_CNT, 2'(k)));
            dist_k = (cnt_p1 > e_k) ? (cnt_p1 - e_k) : (e_k - cnt_p1);
            if (dist_k <= TOL_W) begin
                cls.hit  = 1'b1;
                cls.code = 2'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mcnt       <= '0;
            cand       <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
            meas       <= '0;
            meas_stb   <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            mcnt       <= mcnt_n;
            cand       <= cand_n;
            rate       <= rate_n;
            rate_valid <= rv_n;
            meas       <= meas_n;
            meas_stb   <= stb_n;
            err        <= err_n;
            timeout    <= to_n;
        end
    end

    always_comb begin
        state_n  = state;
        mcnt_n   = mcnt;
        cand_n   = cand;
        rate_n   = rate;
        rv_n     = rate_valid;
        meas_n   = meas;
        stb_n    = 1'b0;
        err_n    = 1'b0;
        to_n     = 1'b0;
        mcnt_nxt = MC_ONE;

        if (edge_stb) begin
            cnt_n = '0;
        end else if (&cnt) begin
            cnt_n = cnt;
        end else begin
            cnt_n = cnt_p1[CNT_W-1:0];
        end

        unique case (state)
            IDLE: begin
                if (edge_stb) begin
                    state_n = PRIMED;
                    mcnt_n  = '0;
                end
            end
            PRIMED: begin
                if (edge_stb) begin
                    meas_n = meas_sat;
                    stb_n  = 1'b1;
                    if (!cls.hit) begin
                        err_n  = 1'b1;
                        mcnt_n = '0;
                    end else begin
                        if (cls.code == cand) begin
                            mcnt_nxt = mcnt + MC_ONE;
                        end
                        cand_n = cls.code;
                        mcnt_n = mcnt_nxt;
                        if (mcnt_nxt >= LOCK_LIM) begin
                            state_n = LOCKED;
                            rate_n  = cls.code;
                            rv_n    = 1'b1;
                        end
                    end
                end else if (to_hit) begin
                    to_n    = 1'b1;
                    state_n = IDLE;
                    rv_n    = 1'b0;
                    mcnt_n  = '0;
                end
            end
            LOCKED: begin
                if (edge_stb) begin
                    meas_n = meas_sat;
                    stb_n  = 1'b1;
                    if (!cls.hit || cls.code != rate) begin
                        err_n   = 1'b1;
                        rv_n    = 1'b0;
                        state_n = PRIMED;
                        mcnt_n  = '0;
                        if (cls.hit) begin
                            cand_n = cls.code;
                            mcnt_n = MC_ONE;
                        end
                    end
                end else if (to_hit) begin
                    to_n    = 1'b1;
                    state_n = IDLE;
                    rv_n    = 1'b0;
                    mcnt_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tick_rate_detect.sv
// Self-checking bench for tick_rate_detect (BASE_CNT=10, TOL=2, LOCK_N=2).
// Table-driven toggle intervals feed a scoreboard checked by a negedge monitor.
`timescale 1ns/1ps
module tb_tick_rate_detect;

    // Intervals 11/21/41/81; the timeout pulse lands when cnt+1 reaches
    // E3+TOL+1 = 84, i.e. 84 cycles after the measuring edge is registered.
    localparam int TO_DLY = 84;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_game = 1'b0;
    logic [1:0]  rate;
    logic        rate_valid;
    logic [31:0] meas;
    logic        meas_stb;
    logic        err;
    logic        timeout;

    tick_rate_detect #(
        .BASE_CNT (10),
        .TOL      (2),
        .LOCK_N   (2),
        .CNT_W    (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_game   (clk_game),
        .rate       (rate),
        .rate_valid (rate_valid),
        .meas       (meas),
        .meas_stb   (meas_stb),
        .err        (err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       due;
        bit       stb;
        int       lo;
        int       hi;
        bit       err;
        bit       to;
        bit       rv;
        bit [1:0] rate;
    } exp_t;

    typedef struct {
        int       n;
        bit       stb;
        int       meas;
        bit       err;
        bit       rv;
        bit [1:0] rate;
    } vec_t;

    exp_t   q[$];
    vec_t   vt[23];
    int     checks = 0;
    int     errors = 0;
    int     last_cyc = 0;
    longint last_t = 0;
    bit     mon_en = 1'b0;
    exp_t   me;
    logic   mev;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at cyc %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int due, input bit stb, input int lo,
                        input int hi, input bit e, input bit to,
                        input bit rv, input bit [1:0] r);
        exp_t x;
        x.due  = due;
        x.stb  = stb;
        x.lo   = lo;
        x.hi   = hi;
        x.err  = e;
        x.to   = to;
        x.rv   = rv;
        x.rate = r;
        q.push_back(x);
    endtask

    task automatic drive(input int n, input bit stb, input int m,
                         input bit e, input bit rv, input bit [1:0] r);
        repeat (n) @(posedge clk);
        #1 clk_game = ~clk_game;
        last_cyc = cyc;
        last_t   = $time;
        push(cyc + 3, stb, m, m, e, 1'b0, rv, r);
    endtask

    task automatic apply_rows(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            drive(vt[i].n, vt[i].stb, vt[i].meas, vt[i].err,
                  vt[i].rv, vt[i].rate);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mev = meas_stb | err | timeout;
            while (q.size() > 0 && q[0].due >= 0 && q[0].due < cyc) begin
                me = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed: due cyc %0d now %0d", me.due, cyc);
            end
            if (q.size() > 0 &&
                (q[0].due == cyc || (q[0].due < 0 && mev))) begin
                me = q.pop_front();
                chk("meas_stb", 64'(meas_stb), 64'(me.stb));
                chk("err", 64'(err), 64'(me.err));
                chk("timeout", 64'(timeout), 64'(me.to));
                chk("rate_valid", 64'(rate_valid), 64'(me.rv));
                chk("rate", 64'(rate), 64'(me.rate));
                checks++;
                if ($isunknown(meas) || meas < me.lo || meas > me.hi) begin
                    errors++;
                    $display("FAIL meas: got %0d want %0d..%0d at cyc %0d",
                             meas, me.lo, me.hi, cyc);
                end
            end else begin
                chk("quiet", 64'(mev), 64'd0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint base;
        longint tgt;
        int     off;

        //        n   stb   meas err   rv    rate
        vt[0]  = '{5,  1'b0, 0,  1'b0, 1'b0, 2'd0};
        vt[1]  = '{21, 1'b1, 21, 1'b0, 1'b0, 2'd0};
        vt[2]  = '{21, 1'b1, 21, 1'b0, 1'b1, 2'd1};
        vt[3]  = '{21, 1'b1, 21, 1'b0, 1'b1, 2'd1};
        vt[4]  = '{42, 1'b1, 42, 1'b1, 1'b0, 2'd1};
        vt[5]  = '{39, 1'b1, 39, 1'b0, 1'b1, 2'd2};
        vt[6]  = '{42, 1'b1, 42, 1'b0, 1'b1, 2'd2};
        vt[7]  = '{44, 1'b1, 44, 1'b1, 1'b0, 2'd2};
        vt[8]  = '{11, 1'b1, 11, 1'b0, 1'b0, 2'd2};
        vt[9]  = '{11, 1'b1, 11, 1'b0, 1'b1, 2'd0};
        vt[10] = '{81, 1'b1, 81, 1'b1, 1'b0, 2'd0};
        vt[11] = '{81, 1'b1, 81, 1'b0, 1'b1, 2'd3};
        vt[12] = '{83, 1'b1, 83, 1'b0, 1'b1, 2'd3};
        vt[13] = '{9,  1'b1, 9,  1'b1, 1'b0, 2'd3};
        vt[14] = '{8,  1'b1, 8,  1'b1, 1'b0, 2'd3};
        vt[15] = '{13, 1'b1, 13, 1'b0, 1'b0, 2'd3};
        vt[16] = '{19, 1'b1, 19, 1'b0, 1'b0, 2'd3};
        vt[17] = '{23, 1'b1, 23, 1'b0, 1'b1, 2'd1};
        vt[18] = '{79, 1'b1, 79, 1'b1, 1'b0, 2'd1};
        vt[19] = '{81, 1'b1, 81, 1'b0, 1'b1, 2'd3};
        vt[20] = '{84, 1'b1, 84, 1'b1, 1'b0, 2'd3};
        vt[21] = '{81, 1'b1, 81, 1'b0, 1'b0, 2'd3};
        vt[22] = '{81, 1'b1, 81, 1'b0, 1'b1, 2'd3};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rate", 64'(rate), 64'd0);
        chk("rst_rate_valid", 64'(rate_valid), 64'd0);
        chk("rst_meas", 64'(meas), 64'd0);
        chk("rst_meas_stb", 64'(meas_stb), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        mon_en = 1'b1;

        apply_rows(0, 22);

        push(last_cyc + 3 + TO_DLY, 1'b0, 81, 81, 1'b0, 1'b1, 1'b0, 2'd3);
        repeat (TO_DLY + 100) @(posedge clk);
        drive(1, 1'b0, 81, 1'b0, 1'b0, 2'd3);
        drive(21, 1'b1, 21, 1'b0, 1'b0, 2'd3);
        drive(21, 1'b1, 21, 1'b0, 1'b1, 2'd1);

        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        clk_game = 1'b0;
        push(cyc + 1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply_rows(0, 3);

        // Free-running toggles off the clk grid with ~21 +/- 1 cycle spacing.
        base = last_t - 6;
        for (int i = 1; i <= 12; i++) begin
            off = int'($urandom_range(0, 13)) - 4;
            if (off == 5) off = 6;
            tgt = base + longint'(i) * 210 + longint'(off);
            #(tgt - $time);
            clk_game = ~clk_game;
            push(-1, 1'b1, 20, 22, 1'b0, 1'b0, 1'b1, 2'd1);
        end

        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("end_rate_valid", 64'(rate_valid), 64'd1);
        chk("end_rate", 64'(rate), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_rate_detect.md
Name: tick_rate_detect

Overview:
- Receive-side counterpart of the game-tick divider: samples the divided `clk_game` square wave in the `clk` domain.
- Measures the interval between its toggles and decodes which 2-bit rate code (ratio 1/2/4/8) produced it.
- Reports code, lock status, raw measurement and error/timeout events.
- Sits beside the game logic for self-check of the tick generator and for adapting to an externally supplied tick.

Parameters:
- BASE_CNT, 12500: divider base count; expected toggle interval for code k is E_k = BASE_CNT*2^k + 1 clk cycles.
- TOL, 64: accepted deviation in cycles, inclusive: |meas - E_k| <= TOL.
- LOCK_N, 2: consecutive equal-code measurements required to lock (>= 1).
- CNT_W, 32: width of the interval counter and of `meas`.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- clk_game, input, 1: tick waveform under test; may be asynchronous to `clk`.
- rate, output, 2: decoded rate code; 0..3 maps to ratio 1, 2, 4, 8.
- rate_valid, output, 1: high while locked.
- meas, output, CNT_W: last measured toggle interval in clk cycles.
- meas_stb, output, 1: one-cycle pulse when `meas` updates.
- err, output, 1: one-cycle pulse when a measurement matches no code, or a locked code changes.
- timeout, output, 1: one-cycle pulse when no toggle arrives within E_3 + TOL cycles.

Behaviour:
- **Reset** (rst high at a posedge `clk`):
  - Clears synchronizer flops, counter, match counter and state.
  - Output reset values: rate=0, rate_valid=0, meas=0, meas_stb=0, err=0, timeout=0, state=IDLE.
  - Reset mid-measurement discards the partial interval.
- **Synchronizer and edge detect**:
  - `clk_game` passes through 2 flops (s1, s2), then a history flop s3.
  - edge = s2 ^ s3; both rising and falling toggles count.
  - All outputs are registered and update on the clk edge where edge=1, so they are visible the next cycle.
  - Latency from a `clk_game` change to `meas_stb` is 3 cycles when the change is synchronous to `clk`.
- **Counter `cnt`**:
  - Cleared to 0 on an edge cycle, otherwise incremented.
  - Saturates at all-ones; it never wraps.
  - Measured interval = cnt + 1, so a divider toggling every N cycles yields meas = N.
- **Classification**:
  - code k is the unique k with |meas - E_k| <= TOL.
  - No such k means a miss.
  - If TOL permits overlap, the lowest k wins.
  - Arithmetic uses CNT_W+1 bits, unsigned, with no underflow: compute the distance as max minus min.
- **States**:
  - IDLE: waits for the first edge and produces no measurement. On an edge it goes to PRIMED; meas is not updated.
  - PRIMED:
    - On each edge: meas <= cnt+1 and meas_stb pulses.
    - Miss: err pulses and the match count is cleared.
    - Hit with code == previous candidate: match count increments. Hit with a different code: the candidate is replaced and the match count set to 1.
    - When the match count reaches LOCK_N: go to LOCKED, rate <= candidate, rate_valid <= 1.
  - LOCKED:
    - Edge with the same code: meas/meas_stb update; everything else holds.
    - Edge that is a miss or a different code: err pulses, rate_valid <= 0, state becomes PRIMED with the match count cleared. A different code becomes the new candidate with count 1. `rate` holds its old value.
- **Timeout**:
  - In PRIMED or LOCKED, when cnt+1 reaches E_3 + TOL + 1 with no edge, timeout pulses exactly once.
  - The block then goes to IDLE, rate_valid <= 0, and the match count is cleared.
  - The next edge re-primes and does not produce a measurement.
  - Timeout and edge in the same cycle: the edge wins and timeout does not fire.
- Glitches shorter than one `clk` period may be missed; this is acceptable. Two edges in consecutive cycles give meas=1, which is a miss.

Decomposition:
- Shared package holds:
  - rate code constants RATE_X1..RATE_X8 (0..3);
  - a function `expected_interval(base, code)` returning base*2^code+1;
  - the state enum IDLE/PRIMED/LOCKED.
- One sub-module, sync_edge_det: 2-flop synchronizer plus history flop, outputs `edge`. Reusable for button inputs.

Test Plan:
Bench parameters: BASE_CNT=10, TOL=2, LOCK_N=2. Expected intervals are 11/21/41/81 and the timeout threshold is 83.
1. Drive toggles every 21 cycles after reset. Required: first edge gives no meas_stb; next edges give meas=21 with meas_stb; rate_valid rises after the second measurement with rate=1; err stays 0.
2. Toggles every 42, then 39 cycles. Required: both classify as code 2 and lock with rate=2. Then an interval of 44 gives err pulse, rate_valid=0, meas=44.
3. Locked at code 0 (interval 11), switch to interval 81. Required: err on the first 81; relock rate=3 after the second consecutive 81.
4. Locked at code 3, then hold clk_game constant. Required: a single timeout pulse 83 cycles after the last edge counter clear; rate_valid=0; no further pulses. The next edge gives no meas_stb; the one after gives a measurement.
5. Assert rst mid-interval while locked. Required: all outputs return to reset values the next cycle; subsequent behaviour matches scenario 1.
6. Toggle clk_game asynchronously (jittered period 21±1). Required: stays locked at rate=1; meas in 20..22; no err.
